// File: rtl/video_timing_gen.sv
// Raster timing generator: sync, data-enable, coordinates, per-line prefetch
// request and frame pacing, all registered and aligned to the presented (x,y).
module video_timing_gen #(
  parameter int   H_ACTIVE  = 800,
  parameter int   H_FP      = 40,
  parameter int   H_SYNC    = 128,
  parameter int   H_BP      = 88,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FP      = 1,
  parameter int   V_SYNC    = 3,
  parameter int   V_BP      = 21,
  parameter logic HS_POL    = 1'b0,
  parameter logic VS_POL    = 1'b0,
  parameter int   LINE_LEAD = 16,
  parameter int   CW        = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic          line_req,
  output logic [CW-1:0] req_y,
  output logic [15:0]   frame_cnt,
  output logic          running
);

  localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_BEG = H_ACTIVE + H_FP;
  localparam int H_SYNC_END = H_SYNC_BEG + H_SYNC;
  localparam int V_SYNC_BEG = V_ACTIVE + V_FP;
  localparam int V_SYNC_END = V_SYNC_BEG + V_SYNC;
  localparam int H_REQ      = H_TOTAL - LINE_LEAD;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    RUN          = 2'd1,
    STOP_PENDING = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          en_q;
  logic [CW-1:0] h_q, h_d, v_q, v_d;
  logic [CW-1:0] h_adv, v_adv;
  logic          at_h_end, at_v_end;

  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          de_q, de_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic          line_req_q, line_req_d;
  logic [CW-1:0] req_y_q, req_y_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic          running_q, running_d;

  int            nh_i, nv_i, nl_i;

  assign at_h_end = (int'(h_q) == H_TOTAL - 1);
  assign at_v_end = (int'(v_q) == V_TOTAL - 1);

  always_comb begin
    h_adv = h_q + CW'(1);
    v_adv = v_q;
    if (at_h_end) begin
      h_adv = '0;
      v_adv = at_v_end ? '0 : v_q + CW'(1);
    end
  end

  // en is registered first, so every decision below uses the previous-edge sample.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    unique case (state_q)
      IDLE: begin
        h_d = '0;
        v_d = '0;
        if (en_q) state_d = RUN;
      end
      RUN: begin
        h_d     = h_adv;
        v_d     = v_adv;
        state_d = en_q ? RUN : STOP_PENDING;
      end
      STOP_PENDING: begin
        if (at_h_end && at_v_end && !en_q) begin
          state_d = IDLE;
          h_d     = '0;
          v_d     = '0;
        end else begin
          h_d     = h_adv;
          v_d     = v_adv;
          state_d = en_q ? RUN : STOP_PENDING;
        end
      end
      default: begin
        state_d = IDLE;
        h_d     = '0;
        v_d     = '0;
      end
    endcase
  end

  // Outputs are decoded from the next position so they land with x/y.
  always_comb begin
    nh_i      = int'(h_d);
    nv_i      = int'(v_d);
    nl_i      = (nv_i == V_TOTAL - 1) ? 0 : nv_i + 1;
    running_d = (state_d != IDLE);

    de_d          = running_d && (nh_i < H_ACTIVE) && (nv_i < V_ACTIVE);
    hsync_d       = (running_d && nh_i >= H_SYNC_BEG && nh_i < H_SYNC_END) ? HS_POL : ~HS_POL;
    vsync_d       = (running_d && nv_i >= V_SYNC_BEG && nv_i < V_SYNC_END) ? VS_POL : ~VS_POL;
    line_start_d  = running_d && (nh_i == 0) && (nv_i < V_ACTIVE);
    frame_start_d = running_d && (nh_i == 0) && (nv_i == 0);

    // No prefetch of line 0 when the coming frame is going to be skipped.
    line_req_d = running_d && (nh_i == H_REQ) && (nl_i < V_ACTIVE) &&
                 !((nl_i == 0) && (state_d == STOP_PENDING));
    req_y_d    = line_req_d ? CW'(nl_i) : req_y_q;

    frame_cnt_d = frame_cnt_q + (frame_start_d ? 16'd1 : 16'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      en_q          <= 1'b0;
      h_q           <= '0;
      v_q           <= '0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      de_q          <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      line_req_q    <= 1'b0;
      req_y_q       <= '0;
      frame_cnt_q   <= 16'd0;
      running_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      en_q          <= en;
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      line_req_q    <= line_req_d;
      req_y_q       <= req_y_d;
      frame_cnt_q   <= frame_cnt_d;
      running_q     <= running_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = h_q;
  assign y           = v_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign line_req    = line_req_q;
  assign req_y       = req_y_q;
  assign frame_cnt   = frame_cnt_q;
  assign running     = running_q;

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Raster timing generator clocked by the pixel clock from the Gowin rPLL divided output (clkoutd). It produces LCD/HDMI sync, data-enable and pixel coordinates. It also issues a per-line prefetch request so the frame-buffer reader can fill its line buffer before the next active line. It sits between the PLL and the pixel pipeline and paces Bad Apple frame playback through frame_start and frame_cnt.

## Interface
- H_ACTIVE, 800, active pixels per line
- H_FP, 40, horizontal front porch (clocks)
- H_SYNC, 128, hsync width (clocks)
- H_BP, 88, horizontal back porch (clocks)
- V_ACTIVE, 480, active lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 3, vsync width (lines)
- V_BP, 21, vertical back porch (lines)
- HS_POL, 0, asserted level of hsync
- VS_POL, 0, asserted level of vsync
- LINE_LEAD, 16, clocks before line end at which line_req fires; legal range is 1..H_TOTAL-1
- CW, 11, coordinate counter width; H_TOTAL and V_TOTAL must each be at most 2^CW
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  run request, sampled on each rising edge
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- de  out  1  active-video data enable
- x  out  CW  horizontal position counter h
- y  out  CW  vertical position counter v
- line_start  out  1  one-clock pulse at h=0 of each active line
- frame_start  out  1  one-clock pulse at position (0,0)
- line_req  out  1  one-clock prefetch request
- req_y  out  CW  line number requested; valid while line_req=1, held otherwise
- frame_cnt  out  16  count of frames started
- running  out  1  high in the RUN and STOP_PENDING states

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- States:
  - IDLE: h=v=0, all pulses 0, de=0, syncs at their inactive level.
  - RUN: counters advance every clock.
  - STOP_PENDING: counters advance; the frame in progress runs to completion.
- IDLE→RUN when en=1. The next cycle presents position (0,0).
- RUN→STOP_PENDING when en=0. STOP_PENDING→RUN when en=1 again; the raster is not disturbed.
- STOP_PENDING→IDLE on the clock after (H_TOTAL-1, V_TOTAL-1). The raster does not wrap to (0,0).
- RUN at (H_TOTAL-1, V_TOTAL-1) wraps to (0,0).
- Counter advance: h increments, and h=H_TOTAL-1 wraps to 0 with v incremented. v=V_TOTAL-1 wraps to 0.
- Output decode:
  - de = (h<H_ACTIVE) && (v<V_ACTIVE).
  - hsync = HS_POL when H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC; otherwise ~HS_POL.
  - vsync = VS_POL when V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC, for every clock of those lines; otherwise ~VS_POL.
  - line_start = (h==0) && (v<V_ACTIVE).
  - frame_start = (h==0) && (v==0) in a running state.
- line_req fires at h==H_TOTAL-LINE_LEAD when the next line nv = (v+1) mod V_TOTAL satisfies nv<V_ACTIVE. req_y=nv.
  - line_req is suppressed for nv=0 in STOP_PENDING, because that frame will not occur.
  - For nv=0 in RUN, line_req fires during the last line of the previous frame.
- frame_cnt increments (mod 2^16) in the same cycle frame_start is high, and is cleared by reset only.

## Timing
- Reset values: hsync=~HS_POL, vsync=~VS_POL, de=0, x=0, y=0, line_start=0, frame_start=0, line_req=0, req_y=0, frame_cnt=0, running=0, state IDLE.
- All outputs are registered and mutually aligned. Each output presented in a cycle is decoded from the (h,v) presented as x,y in that same cycle. There is no skew between de/syncs and x/y.
- Start latency: en sampled high at edge k in IDLE gives running=1, de=1, frame_start=1, line_start=1 and x=y=0 after edge k+1.
- Stop: en low anywhere in a frame completes that frame. After the edge following the last pixel, running=0, de=0 and syncs are inactive.
- en=0 then en=1 within the same frame: the stop is cancelled and the wrap to (0,0) occurs normally.
- Reset asserted mid-frame forces reset values immediately (asynchronously). Release restarts in IDLE.

## Test plan
- Reset and idle: hold rst_n=0, then release with en=0 for 20 clocks -> all outputs at reset values, hsync=vsync=1 for POL=0.
- Small frame: H=4/1/2/1, V=3/1/1/1, LINE_LEAD=2, en=1 held -> period of 48 clocks.
  - frame_start at cycles 1 and 49.
  - hsync low at h=5,6.
  - vsync low for all of v=4.
  - de high for 12 clocks per frame.
  - frame_cnt=2 after cycle 49.
- Prefetch, same parameters -> line_req at h=6 of v=0,1 with req_y=1,2, and at h=6 of v=5 with req_y=0; no line_req on v=2,3,4.
- Stop: drop en at v=1,h=2 -> raster completes through (7,5), and running=0 on the next clock. No line_req for y=0 during v=5.
- Stop cancel: drop en for 3 clocks mid-frame -> uninterrupted wrap to (0,0) and frame_cnt increments.
- Async reset at v=2,h=3 -> outputs reach reset values without a clock edge. After release and en=1, frame_start occurs one clock later with frame_cnt=1.
